// File: rtl/stack_arb.sv
// Two-requester (CPU, debug) arbiter in front of an external LIFO stack; owns the stack pointer.
// Optional high-water-mark output is enabled with the STACK_ARB_HWM_EN macro.
module stack_arb #(
  parameter int WIDTH  = 11,
  parameter int DEPTH  = 7,
  parameter int STARVE = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             cpu_push,
  input  logic             cpu_pop,
  input  logic [WIDTH-1:0] cpu_din,
  output logic [WIDTH-1:0] cpu_dout,
  output logic             cpu_valid,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_din,
  output logic             dbg_gnt,
  output logic [WIDTH-1:0] dbg_dout,
  output logic             dbg_valid,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_in,
  input  logic [WIDTH-1:0] stk_out,
  output logic [DEPTH:0]   depth,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr
`ifdef STACK_ARB_HWM_EN
  ,
  output logic [DEPTH:0]   hwm
`endif
);

  localparam int CW = (STARVE < 3) ? 2 : $clog2(STARVE + 1);
  localparam logic [CW-1:0]  WAIT_LIM = CW'(STARVE - 1);
  localparam logic [CW-1:0]  WAIT_SAT = CW'(STARVE);
  localparam logic [CW-1:0]  WAIT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DEPTH:0] CAP_V    = {1'b1, {DEPTH{1'b0}}};
  localparam logic [DEPTH:0] D_ONE    = {{DEPTH{1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_FORCE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic [DEPTH:0]   depth_q, depth_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic             cpu_valid_q, cpu_valid_d;
  logic             dbg_valid_q, dbg_valid_d;
  logic [WIDTH-1:0] cpu_hold_q, cpu_hold_d;
  logic [WIDTH-1:0] dbg_hold_q, dbg_hold_d;

  logic             cpu_req, dbg_live, forced;
  logic             cpu_go, dbg_go, op_valid, op_push;
  logic [WIDTH-1:0] op_din;
  logic             full_w, empty_w;
  logic             do_push, do_pop, ovf_evt, unf_evt;
  logic [CW-1:0]    wait_inc;

  // Requests are ignored while resetq=0 so no stack strobe or grant escapes during reset.
  always_comb begin
    cpu_req  = resetq & (cpu_push | cpu_pop);
    dbg_live = resetq & dbg_req;
    forced   = (state_q == ST_FORCE);
    cpu_go   = cpu_req & ~forced;
    dbg_go   = dbg_live & (~cpu_req | forced);
    op_valid = cpu_go | dbg_go;
    op_push  = cpu_go ? cpu_push : dbg_we;
    op_din   = cpu_go ? cpu_din : dbg_din;
    full_w   = (depth_q == CAP_V);
    empty_w  = (depth_q == '0);
    do_push  = op_valid & op_push & ~full_w;
    ovf_evt  = op_valid & op_push & full_w;
    do_pop   = op_valid & ~op_push & ~empty_w;
    unf_evt  = op_valid & ~op_push & empty_w;
  end

  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + D_ONE;
    end else if (do_pop) begin
      depth_d = depth_q - D_ONE;
    end
    err_ovf_d   = (err_ovf_q & ~err_clr) | ovf_evt;
    err_unf_d   = (err_unf_q & ~err_clr) | unf_evt;
    cpu_valid_d = do_pop & cpu_go;
    dbg_valid_d = do_pop & dbg_go;
    cpu_hold_d  = cpu_valid ? stk_out : cpu_hold_q;
    dbg_hold_d  = dbg_valid ? stk_out : dbg_hold_q;
  end

  // Starvation FSM: FORCE lasts exactly one cycle and hands that cycle to debug.
  always_comb begin
    state_d  = ST_IDLE;
    wait_inc = (wait_q == WAIT_SAT) ? WAIT_SAT : (wait_q + WAIT_ONE);
    wait_d   = wait_q;
    if (dbg_go) begin
      wait_d = '0;
    end else if (dbg_live) begin
      wait_d = wait_inc;
    end
    if ((state_q == ST_IDLE) && dbg_live && !dbg_go && (wait_inc >= WAIT_LIM)) begin
      state_d = ST_FORCE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      depth_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      cpu_valid_q <= 1'b0;
      dbg_valid_q <= 1'b0;
      cpu_hold_q  <= '0;
      dbg_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      depth_q     <= depth_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
      cpu_valid_q <= cpu_valid_d;
      dbg_valid_q <= dbg_valid_d;
      cpu_hold_q  <= cpu_hold_d;
      dbg_hold_q  <= dbg_hold_d;
    end
  end

`ifdef STACK_ARB_HWM_EN
  logic [DEPTH:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (err_clr) begin
      hwm_d = depth_d;
    end else if (depth_d > hwm_q) begin
      hwm_d = depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetq) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

  // *_valid is a one-cycle pulse; *_dout shows stk_out during it and holds that value afterwards.
  assign cpu_valid = cpu_valid_q & resetq;
  assign dbg_valid = dbg_valid_q & resetq;
  assign cpu_dout  = cpu_valid ? stk_out : cpu_hold_q;
  assign dbg_dout  = dbg_valid ? stk_out : dbg_hold_q;
  assign cpu_stall = cpu_req & forced;
  assign dbg_gnt   = dbg_go;
  assign stk_push  = do_push;
  assign stk_pop   = do_pop;
  assign stk_in    = op_din;
  assign depth     = depth_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_stack_arb.sv
// Randomised and directed bench for stack_arb with a queue-based stack reference model.
module tb_stack_arb;
  localparam int W   = 11;
  localparam int D   = 2;
  localparam int S   = 8;
  localparam int CAP = 1 << D;

  logic         clk = 1'b0;
  logic         resetq = 1'b0;
  logic         cpu_push = 1'b0, cpu_pop = 1'b0;
  logic [W-1:0] cpu_din = '0;
  logic [W-1:0] cpu_dout;
  logic         cpu_valid, cpu_stall;
  logic         dbg_req = 1'b0, dbg_we = 1'b0;
  logic [W-1:0] dbg_din = '0;
  logic         dbg_gnt;
  logic [W-1:0] dbg_dout;
  logic         dbg_valid;
  logic         stk_push, stk_pop;
  logic [W-1:0] stk_in;
  logic [W-1:0] stk_out = '0;
  logic [D:0]   depth;
  logic         full, empty, err_ovf, err_unf;
  logic         err_clr = 1'b0;
`ifdef STACK_ARB_HWM_EN
  logic [D:0]   hwm;
`endif

  stack_arb #(.WIDTH(W), .DEPTH(D), .STARVE(S)) dut (
    .clk(clk), .resetq(resetq),
    .cpu_push(cpu_push), .cpu_pop(cpu_pop), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_valid(cpu_valid), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_din(dbg_din), .dbg_gnt(dbg_gnt),
    .dbg_dout(dbg_dout), .dbg_valid(dbg_valid),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_in(stk_in), .stk_out(stk_out),
    .depth(depth), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_clr(err_clr)
`ifdef STACK_ARB_HWM_EN
    , .hwm(hwm)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // External stack memory driven by the DUT strobes
  logic [W-1:0] mem_q[$];
  always @(posedge clk) begin
    if (!resetq) begin
      mem_q.delete();
    end else if (stk_push) begin
      mem_q.push_back(stk_in);
    end else if (stk_pop && mem_q.size() > 0) begin
      stk_out <= mem_q.pop_back();
    end
  end

  // Scoreboard
  typedef struct {
    bit           chk_regs;
    logic         gnt, stall, spush, spop;
    logic [W-1:0] sin;
    logic [D:0]   depth;
    logic         full, empty, ovf, unf, cval, dval;
    logic [W-1:0] cdout, ddout;
    logic [D:0]   hwm;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] cpu_exp_q[$];
  logic [W-1:0] dbg_exp_q[$];
  int           n_total = 0;
  int           n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model state
  logic [W-1:0] m_stk[$];
  bit           m_known = 0;
  bit           m_ovf = 0, m_unf = 0, m_force = 0;
  int           m_waited = 0;
  bit           m_pend_cpu = 0, m_pend_dbg = 0;
  logic [W-1:0] m_pend_data = '0, m_chold = '0, m_dhold = '0;
  int           m_hwm = 0;

  // Driver: apply one cycle of inputs and record what the DUT must show in that cycle
  task automatic step(input bit rn, input bit cp, input bit cpo, input logic [W-1:0] cd,
                      input bit dr, input bit dw, input logic [W-1:0] dd, input bit clr);
    exp_t e;
    bit cpu_req, gnt, cpu_served, is_push, has_op, own_cpu;
    logic [W-1:0] din;
    @(negedge clk);
    resetq = rn; cpu_push = cp; cpu_pop = cpo; cpu_din = cd;
    dbg_req = dr; dbg_we = dw; dbg_din = dd; err_clr = clr;
    e = '{default: '0};
    e.chk_regs = m_known;
    e.depth = (D+1)'(m_stk.size());
    e.full  = (m_stk.size() == CAP);
    e.empty = (m_stk.size() == 0);
    e.ovf = m_ovf; e.unf = m_unf;
    e.cval = m_pend_cpu && rn;
    e.dval = m_pend_dbg && rn;
    e.cdout = m_chold; e.ddout = m_dhold;
    e.hwm = (D+1)'(m_hwm);
    if (e.cval) cpu_exp_q.push_back(m_pend_data);
    if (e.dval) dbg_exp_q.push_back(m_pend_data);
    if (!rn) begin
      exp_q.push_back(e);
      m_stk.delete();
      m_known = 1; m_ovf = 0; m_unf = 0; m_force = 0; m_waited = 0;
      m_pend_cpu = 0; m_pend_dbg = 0; m_chold = '0; m_dhold = '0; m_hwm = 0;
    end else begin
      if (e.cval) m_chold = m_pend_data;
      if (e.dval) m_dhold = m_pend_data;
      m_pend_cpu = 0; m_pend_dbg = 0;
      cpu_req    = cp || cpo;
      gnt        = dr && (!cpu_req || m_force);
      cpu_served = cpu_req && !m_force;
      e.gnt   = gnt;
      e.stall = cpu_req && m_force;
      has_op  = cpu_served || gnt;
      own_cpu = cpu_served;
      is_push = cpu_served ? cp : dw;
      din     = cpu_served ? cd : dd;
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (has_op && is_push) begin
        if (m_stk.size() < CAP) begin
          e.spush = 1; e.sin = din; m_stk.push_back(din);
        end else m_ovf = 1;
      end else if (has_op) begin
        if (m_stk.size() > 0) begin
          e.spop = 1; m_pend_data = m_stk.pop_back();
          if (own_cpu) m_pend_cpu = 1; else m_pend_dbg = 1;
        end else m_unf = 1;
      end
      if (clr) m_hwm = m_stk.size();
      else if (m_stk.size() > m_hwm) m_hwm = m_stk.size();
      // Starvation: debug gets a forced cycle once it has waited STARVE-1 cycles
      if (gnt) m_waited = 0;
      else if (dr) m_waited++;
      m_force = !m_force && dr && !gnt && (m_waited >= S - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, 0, '0, 0);
  endtask

  // Monitor: compare each cycle's outputs against the recorded expectation
  exp_t mon_e;
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dbg_gnt", dbg_gnt, mon_e.gnt);
      chk("cpu_stall", cpu_stall, mon_e.stall);
      chk("stk_push", stk_push, mon_e.spush);
      chk("stk_pop", stk_pop, mon_e.spop);
      if (mon_e.spush) chk("stk_in", stk_in, mon_e.sin);
      chk("cpu_valid", cpu_valid, mon_e.cval);
      chk("dbg_valid", dbg_valid, mon_e.dval);
      if (mon_e.chk_regs) begin
        chk("depth", depth, mon_e.depth);
        chk("full", full, mon_e.full);
        chk("empty", empty, mon_e.empty);
        chk("err_ovf", err_ovf, mon_e.ovf);
        chk("err_unf", err_unf, mon_e.unf);
`ifdef STACK_ARB_HWM_EN
        chk("hwm", hwm, mon_e.hwm);
`endif
        if (cpu_valid) begin
          if (cpu_exp_q.size() == 0) chk("cpu_valid_unexpected", cpu_valid, 0);
          else chk("cpu_dout", cpu_dout, cpu_exp_q.pop_front());
        end else chk("cpu_dout_hold", cpu_dout, mon_e.cdout);
        if (dbg_valid) begin
          if (dbg_exp_q.size() == 0) chk("dbg_valid_unexpected", dbg_valid, 0);
          else chk("dbg_dout", dbg_dout, dbg_exp_q.pop_front());
        end else chk("dbg_dout_hold", dbg_dout, mon_e.ddout);
      end
    end
  end

  // Stimulus
  int gnt_seen;
  initial begin
    // reset, push 1,2,3, pop
    step(0, 0, 0, '0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0, 0, '0, 0);
    step(1, 1, 0, 11'h001, 0, 0, '0, 0);
    step(1, 1, 0, 11'h002, 0, 0, '0, 0);
    step(1, 1, 0, 11'h003, 0, 0, '0, 0);
    step(1, 0, 1, '0, 0, 0, '0, 0);
    idle(2);
    // pop on empty, then clear
    step(0, 0, 0, '0, 0, 0, '0, 0);
    step(1, 0, 1, '0, 0, 0, '0, 0);
    idle(1);
    step(1, 0, 0, '0, 0, 0, '0, 1);
    idle(1);
    // overflow: five pushes into four entries, push+pop together acts as push
    for (int i = 0; i < 5; i++) step(1, 1, (i == 4), W'(16 + i), 0, 0, '0, 0);
    idle(1);
    // starvation: CPU pushes every cycle while debug holds a pop request
    step(0, 0, 0, '0, 0, 0, '0, 0);
    gnt_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, W'(32 + i), 1, 0, '0, 0);
      #3;
      if (i < 8) gnt_seen += int'(dbg_gnt);
    end
    chk("dbg_gnt_first8", 32'(gnt_seen), 1);
    // debug pop with CPU idle at depth 1
    step(0, 0, 0, '0, 0, 0, '0, 0);
    step(1, 1, 0, 11'h155, 0, 0, '0, 0);
    step(1, 0, 0, '0, 1, 0, '0, 0);
    idle(2);
    // reset in the cycle after a pop suppresses the valid pulse
    step(1, 1, 0, 11'h0aa, 0, 0, '0, 0);
    step(1, 0, 1, '0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0, 0, '0, 0);
    idle(2);
    // random traffic with a heavy-CPU stretch to provoke starvation
    for (int i = 0; i < 800; i++) begin
      int pcpu;
      pcpu = (i >= 250 && i < 450) ? 90 : 40;
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 99) < pcpu, $urandom_range(0, 99) < 35, W'($urandom),
           $urandom_range(0, 99) < 45, $urandom_range(0, 1) == 1, W'($urandom),
           $urandom_range(0, 99) < 5);
    end
    idle(3);
    @(negedge clk);
    #5;
    chk("cpu_exp_drained", 32'(cpu_exp_q.size()), 0);
    chk("dbg_exp_drained", 32'(dbg_exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stack_arb.md
STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 11, meaning stack entry width in bits.
REQ-002 SHALL have parameter DEPTH, default 7, meaning log2 of the number of stack entries (capacity CAP = 2^DEPTH).
REQ-003 SHALL have parameter STARVE, default 8, meaning the number of cycles debug may wait before a forced grant.
REQ-004 Ports: clk in 1, the single clock; resetq in 1, synchronous active-low reset.
REQ-005 Ports: cpu_push in 1; cpu_pop in 1; cpu_din in WIDTH; cpu_dout out WIDTH, popped data; cpu_valid out 1, cpu_dout valid; cpu_stall out 1, CPU request not accepted this cycle.
REQ-006 Ports: dbg_req in 1; dbg_we in 1 (1 = push, 0 = pop); dbg_din in WIDTH; dbg_gnt out 1; dbg_dout out WIDTH; dbg_valid out 1.
REQ-007 Ports: stk_push out 1; stk_pop out 1; stk_in out WIDTH; stk_out in WIDTH, stack read data, valid the cycle after stk_pop.
REQ-008 Ports: depth out DEPTH+1, current entry count; full out 1; empty out 1; err_ovf out 1; err_unf out 1; err_clr in 1.

Function
REQ-009 SHALL issue at most one stack operation per cycle, to exactly one requester.
REQ-010 CPU SHALL have fixed priority, except in state FORCE.
REQ-011 dbg_gnt SHALL assert combinationally in any cycle with dbg_req=1 in which either the CPU has no request or the state is FORCE; the debug operation executes in that cycle.
REQ-012 cpu_stall SHALL be 1 exactly when the CPU has a request and the state is FORCE.
REQ-013 FSM states SHALL be IDLE and FORCE. A wait counter SHALL increment each cycle with dbg_req=1 and dbg_gnt=0.
REQ-014 The FSM SHALL go IDLE->FORCE when the counter reaches STARVE-1 while dbg_req=1 and dbg_gnt=0.
REQ-015 The FSM SHALL go FORCE->IDLE after exactly one cycle; the counter SHALL clear on any dbg_gnt.
REQ-016 CPU push and pop asserted together SHALL be treated as a push.
REQ-017 A push SHALL drive stk_push=1 and stk_in=requester din, and increment depth, only when full=0.
REQ-018 A push when full=1 SHALL issue no stack operation and SHALL set err_ovf; the requester is still considered served.
REQ-019 A pop SHALL drive stk_pop=1 and decrement depth, only when empty=0.
REQ-020 A pop when empty=1 SHALL issue no stack operation, SHALL set err_unf, and SHALL produce no valid pulse.
REQ-021 On a successful pop, the owner's *_valid SHALL pulse for exactly one cycle, the cycle after the pop, with *_dout = stk_out.
REQ-022 Otherwise *_dout SHALL hold its last value.
REQ-023 full SHALL equal (depth == CAP); empty SHALL equal (depth == 0); depth SHALL never wrap.
REQ-024 err_ovf and err_unf SHALL be sticky until err_clr=1.
REQ-025 When err_clr=1 coincides with a new error event, the flag SHALL end up set.
REQ-026 stk_push, stk_pop and *_valid SHALL never assert during reset.

Reset
REQ-027 While resetq=0 at a clk edge, the block SHALL reset state to IDLE and reset the wait counter, depth, err_ovf, err_unf, cpu_valid and dbg_valid to 0.
REQ-028 While resetq=0 at a clk edge, the block SHALL reset cpu_dout and dbg_dout to 0.
REQ-029 Reset asserted mid-operation SHALL suppress a pending valid pulse.
REQ-030 The owner SHALL reset the stack pointer concurrently.

Configuration
REQ-031 With macro STACK_ARB_HWM_EN defined, the block SHALL add output hwm (DEPTH+1 bits), the maximum depth since reset or err_clr, updated the same cycle as depth.
REQ-032 With STACK_ARB_HWM_EN undefined, port hwm and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then 3 CPU pushes 0x001,0x002,0x003, then 1 pop -> depth=2 and cpu_dout=0x003 with cpu_valid 1 cycle after the pop; empty=0.
REQ-034 Empty stack, CPU pop -> no stk_pop, err_unf=1, cpu_valid=0; err_clr pulse -> err_unf=0.
REQ-035 With DEPTH=2, push 5 values -> depth=4, full=1, the 5th push sets err_ovf with no stk_push.
REQ-036 CPU pushes every cycle and dbg_req held with STARVE=8 -> dbg_gnt asserts in the 8th request cycle, cpu_stall=1 that cycle only.
REQ-037 CPU idle, debug pop with depth=1 -> dbg_gnt same cycle, dbg_valid next cycle, depth=0.
REQ-038 resetq=0 in the cycle after a pop -> cpu_valid stays 0 and depth=0.
